router_src_fifo: RTL and testbench



---
 rtl/router_fifo_pkg.sv | 16 +
 rtl/fifo_ram.sv | 21 ++
 rtl/router_src_fifo.sv | 81 ++++++++
 tb/tb_router_src_fifo.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/router_fifo_pkg.sv
// Shared constants and destination-ID helpers for the router source FIFOs.
package router_fifo_pkg;
  localparam int DST_W     = 8;
  localparam int PKT_MAX_W = 256;
  localparam logic [DST_W-1:0] BROADCAST_ID = 8'hFF;

  // Destination ID lives in the top DST_W bits of a sz-bit packet.
  function automatic logic [DST_W-1:0] dst_of(input logic [PKT_MAX_W-1:0] pkt, input int sz);
    return DST_W'(pkt >> (sz - DST_W));
  endfunction

  function automatic logic dst_legal(input logic [DST_W-1:0] dst, input int n,
                                     input logic [DST_W-1:0] bc);
    return (int'({24'd0, dst}) < n) || (dst == bc);
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter  int DEPTH = 16,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/router_src_fifo.sv
// Per-terminal first-word-fall-through source FIFO feeding the router bus,
// with illegal-destination filtering and occupancy/overflow/drop statistics.
module router_src_fifo
  import router_fifo_pkg::*;
#(
  parameter  int         pckg_sz    = 16,
  parameter  int         fifo_depth = 16,
  parameter  int         num_ntrfs  = 4,
  parameter  logic [7:0] broadcast  = BROADCAST_ID,
  localparam int         AW         = $clog2(fifo_depth),
  localparam int         CW         = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] data_in,
  output logic               full,
  output logic               pndng,
  output logic [pckg_sz-1:0] data_out,
  input  logic               popin,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic               underflow,
  output logic [15:0]        drop_cnt
);
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic               overflow_q, underflow_q;
  logic               legal, empty, do_wr, do_pop;
  logic [pckg_sz-1:0] rdata;

  assign legal  = dst_legal(dst_of(PKT_MAX_W'(data_in), pckg_sz), num_ntrfs, broadcast);
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(fifo_depth));
  assign do_pop = popin && !empty;
  // When full, a concurrent pop frees the slot at the same edge.
  assign do_wr  = push && legal && (!full || popin);

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_wr && do_pop) count_d = count_q - 1'b1;
    drop_cnt_d = drop_cnt_q;
    if (push && !legal && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_q | (push && legal && full && !popin);
      underflow_q <= underflow_q | (popin && empty);
    end
  end

  fifo_ram #(.DEPTH(fifo_depth), .W(pckg_sz)) u_ram (
    .clk   (clk),
    .we    (do_wr && !reset),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign pndng     = !empty;
  assign data_out  = empty ? '0 : rdata;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_router_src_fifo.sv
// Directed bench for router_src_fifo: expected packets queued by stimulus,
// popped and compared by a monitor whenever the router side consumes the head.
module tb_router_src_fifo;
  logic        clk = 1'b0;
  logic        reset, push, popin;
  logic [15:0] data_in;
  logic        full, pndng, overflow, underflow;
  logic [15:0] data_out, drop_cnt;
  logic [4:0]  count;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] exp_q[$];

  router_src_fifo #(.pckg_sz(16), .fifo_depth(16), .num_ntrfs(4), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .full(full),
    .pndng(pndng), .data_out(data_out), .popin(popin), .count(count),
    .overflow(overflow), .underflow(underflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare head against scoreboard whenever the router pops it.
  always @(negedge clk) begin
    if (!reset && popin && pndng) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_data: got %0h with scoreboard empty", data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_err++;
          $display("FAIL pop_data: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  // Apply one cycle of inputs (called just after a rising edge), return #1 after the next edge.
  task automatic drive(input logic p, input logic [15:0] d, input logic po);
    push = p; data_in = d; popin = po;
    @(posedge clk); #1;
    push = 1'b0; popin = 1'b0; data_in = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_full"},  32'(full),      32'h0);
    chk({tag, "_pndng"}, 32'(pndng),     32'h0);
    chk({tag, "_dout"},  32'(data_out),  32'h0);
    chk({tag, "_count"}, 32'(count),     32'h0);
    chk({tag, "_ovf"},   32'(overflow),  32'h0);
    chk({tag, "_unf"},   32'(underflow), 32'h0);
    chk({tag, "_drop"},  32'(drop_cnt),  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    reset = 1'b1; push = 1'b0; popin = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_zero("reset");

    // Basic ordering
    exp_q.push_back(16'h0155); drive(1'b1, 16'h0155, 1'b0);
    chk("first_pndng", 32'(pndng), 32'h1);
    chk("first_dout", 32'(data_out), 32'h0155);
    exp_q.push_back(16'h02AA); drive(1'b1, 16'h02AA, 1'b0);
    exp_q.push_back(16'h03C3); drive(1'b1, 16'h03C3, 1'b0);
    chk("three_count", 32'(count), 32'd3);
    repeat (3) drive(1'b0, '0, 1'b1);
    chk("drain_pndng", 32'(pndng), 32'h0);
    chk("drain_count", 32'(count), 32'd0);

    // Fill, then push+pop at full, then overflow
    for (int i = 0; i < 16; i++) begin
      p = 16'h0100 + 16'(i);
      exp_q.push_back(p); drive(1'b1, p, 1'b0);
    end
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'd16);
    exp_q.push_back(16'h03EE); drive(1'b1, 16'h03EE, 1'b1);
    chk("pushpop_count", 32'(count), 32'd16);
    chk("pushpop_ovf", 32'(overflow), 32'h0);
    drive(1'b1, 16'h0299, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_count", 32'(count), 32'd16);
    repeat (16) drive(1'b0, '0, 1'b1);
    chk("ovf_drain_count", 32'(count), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'h1);

    // Destination filtering
    drive(1'b1, 16'h0700, 1'b0);
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
    chk("drop_count0", 32'(count), 32'd0);
    exp_q.push_back(16'hFF12); drive(1'b1, 16'hFF12, 1'b0);
    chk("bc_count", 32'(count), 32'd1);
    chk("bc_dout", 32'(data_out), 32'hFF12);
    chk("bc_drop", 32'(drop_cnt), 32'd1);
    drive(1'b0, '0, 1'b1);

    // Underflow with simultaneous push
    chk("pre_unf", 32'(underflow), 32'h0);
    drive(1'b1, 16'h0011, 1'b1);
    chk("unf_set", 32'(underflow), 32'h1);
    chk("unf_count", 32'(count), 32'd1);
    chk("unf_dout", 32'(data_out), 32'h0011);
    exp_q.push_back(16'h0011);
    drive(1'b0, '0, 1'b1);

    // Streaming through pointer wraps
    p = 16'h0000; exp_q.push_back(p); drive(1'b1, p, 1'b0);
    for (int k = 1; k < 20; k++) begin
      p = {6'd0, 2'(k), 8'(k)};
      exp_q.push_back(p); drive(1'b1, p, 1'b1);
      chk("stream_count", 32'(count), 32'd1);
    end
    chk("stream_head", 32'(data_out), 32'h0313);

    // Reset with a concurrent push discards everything
    reset = 1'b1; push = 1'b1; data_in = 16'h0123;
    @(posedge clk); #1;
    reset = 1'b0; push = 1'b0; data_in = '0;
    exp_q.delete();
    chk_zero("midreset");
    @(posedge clk); #1;
    chk("post_reset_count", 32'(count), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
